// File: rtl/logic_pod_rle_compressor.sv
// rtl/logic_pod_rle_compressor.sv - run-length compressor for one logic-analyzer lane
//
// Purpose: classifies IN_WIDTH-bit sample blocks as one run, two runs or
// verbatim, merges runs across blocks, and emits at most one chunk per clock.
// Three register stages: input capture, classification, merge/output.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   din, in_valid     sample block (MSB = oldest sample) and its qualifier
//   en                capture enable (blocks dropped while low)
//   force_verbatim    classify every block as verbatim
//   flush, flush_done drain request / drain-complete pulse
//   out_valid, out_format, out_data  chunk strobe, 1=verbatim 0=runs, payload
//   stat_blocks_in, stat_chunks_out  statistics (zero unless LOGIC_POD_RLE_STATS_EN)
//
// Optional feature macro: LOGIC_POD_RLE_STATS_EN builds the saturating counters.
module logic_pod_rle_compressor #(
  parameter int IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] din,
  input  logic                in_valid,
  input  logic                en,
  input  logic                force_verbatim,
  input  logic                flush,
  output logic                flush_done,
  output logic                out_valid,
  output logic                out_format,
  output logic [IN_WIDTH-1:0] out_data,
  output logic [31:0]         stat_blocks_in,
  output logic [31:0]         stat_chunks_out
);
  localparam int CB   = IN_WIDTH / 2 - 1;
  localparam int MAXC = (1 << CB) - 1;
  localparam logic [CB:0]   MAXC_X = (CB+1)'(MAXC);
  localparam logic [CB-1:0] MAXC_C = CB'(MAXC);

  // Drain sequencer: 0 idle, 1..3 draining after an accepted flush.
  logic [1:0] drain_q, drain_d;
  logic       accept;
  assign accept = in_valid && en && (drain_q == 2'd0);

  always_comb begin
    drain_d = drain_q;
    if (drain_q != 2'd0) drain_d = drain_q + 2'd1;
    else if (flush)      drain_d = 2'd1;
  end

  // Stage 1: captured block.
  logic                s1_valid_q, s1_fv_q;
  logic [IN_WIDTH-1:0] s1_din_q;

  // Stage 2 classification of the captured block.
  logic [IN_WIDTH-2:0] edges;
  logic [CB-1:0]       k_idx;
  logic                no_edge, one_edge;
  assign edges    = s1_din_q[IN_WIDTH-1:1] ^ s1_din_q[IN_WIDTH-2:0];
  assign no_edge  = (edges == '0);
  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  assign one_edge = !no_edge && ((edges & (edges - (IN_WIDTH-1)'(1))) == '0);

  always_comb begin
    k_idx = '0;
    for (int i = 0; i < IN_WIDTH - 1; i++) begin
      if (edges[i]) k_idx = CB'(i);
    end
  end

  logic                s2_valid_q, s2_verb_q, s2_two_q, s2_v0_q, s2_v1_q;
  logic [CB-1:0]       s2_c0_q, s2_c1_q;
  logic [IN_WIDTH-1:0] s2_data_q;

  // Stage 3 pending state: up to two runs, or one verbatim block.
  logic [1:0]             r_num_q, r_num_d;
  logic [1:0]             r_val_q, r_val_d;
  logic [1:0][CB-1:0]     r_cnt_q, r_cnt_d;
  logic                   v_pend_q, v_pend_d;
  logic [IN_WIDTH-1:0]    v_data_q, v_data_d;

  logic                emit, emit_fmt;
  logic [IN_WIDTH-1:0] emit_data;

  // Working list of up to four runs while merging.
  logic [3:0]         lv;
  logic [3:0][CB-1:0] lc;
  logic [2:0]         n;
  logic [1:0]         last;
  logic               nv;
  logic [CB-1:0]      nc;
  logic [CB:0]        sum;

  always_comb begin
    r_num_d   = r_num_q;
    r_val_d   = r_val_q;
    r_cnt_d   = r_cnt_q;
    v_pend_d  = v_pend_q;
    v_data_d  = v_data_q;
    emit      = 1'b0;
    emit_fmt  = 1'b0;
    emit_data = '0;
    lv        = {2'b00, r_val_q};
    lc        = {{(2*CB){1'b0}}, r_cnt_q};
    n         = {1'b0, r_num_q};
    last      = 2'd0;
    nv        = 1'b0;
    nc        = '0;
    sum       = '0;

    if (s2_valid_q) begin
      // A pending verbatim block always leaves on the next arriving block;
      // runs are never pending alongside it, so the run list starts empty.
      if (v_pend_q) begin
        emit      = 1'b1;
        emit_fmt  = 1'b1;
        emit_data = v_data_q;
        v_pend_d  = 1'b0;
        v_data_d  = '0;
      end
      if (s2_verb_q) begin
        if (v_pend_q) begin
          v_pend_d = 1'b1;
          v_data_d = s2_data_q;
        end else if (r_num_q == 2'd0) begin
          emit      = 1'b1;
          emit_fmt  = 1'b1;
          emit_data = s2_data_q;
        end else begin
          emit      = 1'b1;
          emit_data = {r_val_q[0], r_cnt_q[0], r_val_q[1], r_cnt_q[1]};
          r_num_d   = 2'd0;
          r_val_d   = '0;
          r_cnt_d   = '0;
          v_pend_d  = 1'b1;
          v_data_d  = s2_data_q;
        end
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (j == 0 || s2_two_q) begin
            nv   = (j == 0) ? s2_v0_q : s2_v1_q;
            nc   = (j == 0) ? s2_c0_q : s2_c1_q;
            last = n[1:0] - 2'd1;
            if (n != 3'd0 && lv[last] == nv) begin
              sum = {1'b0, lc[last]} + {1'b0, nc};
              if (sum > MAXC_X) begin
                // Saturate the run and spill the excess into a new run.
                lc[last]    = MAXC_C;
                lv[n[1:0]]  = nv;
                lc[n[1:0]]  = CB'(sum - MAXC_X);
                n           = n + 3'd1;
              end else begin
                lc[last] = sum[CB-1:0];
              end
            end else begin
              lv[n[1:0]] = nv;
              lc[n[1:0]] = nc;
              n          = n + 3'd1;
            end
          end
        end
        if (n > 3'd2) begin
          emit       = 1'b1;
          emit_data  = {lv[0], lc[0], lv[1], lc[1]};
          r_val_d    = lv[3:2];
          r_cnt_d    = {lc[3], lc[2]};
          r_num_d    = 2'(n - 3'd2);
        end else begin
          r_val_d    = lv[1:0];
          r_cnt_d    = {lc[1], lc[0]};
          r_num_d    = n[1:0];
        end
      end
    end

    // Last drain slot: push out whatever is still pending, then start clean.
    // The slot carries a single chunk, so it only adds one when none left yet.
    if (drain_q == 2'd2) begin
      if (!emit) begin
        if (v_pend_d) begin
          emit      = 1'b1;
          emit_fmt  = 1'b1;
          emit_data = v_data_d;
        end else if (r_num_d != 2'd0) begin
          emit      = 1'b1;
          emit_data = {r_val_d[0], r_cnt_d[0], r_val_d[1], r_cnt_d[1]};
        end
      end
      r_num_d  = 2'd0;
      r_val_d  = '0;
      r_cnt_d  = '0;
      v_pend_d = 1'b0;
      v_data_d = '0;
    end
  end

  logic                out_valid_q, out_fmt_q, flush_done_q;
  logic [IN_WIDTH-1:0] out_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_q      <= 2'd0;
      s1_valid_q   <= 1'b0;
      s1_fv_q      <= 1'b0;
      s1_din_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_verb_q    <= 1'b0;
      s2_two_q     <= 1'b0;
      s2_v0_q      <= 1'b0;
      s2_v1_q      <= 1'b0;
      s2_c0_q      <= '0;
      s2_c1_q      <= '0;
      s2_data_q    <= '0;
      r_num_q      <= 2'd0;
      r_val_q      <= '0;
      r_cnt_q      <= '0;
      v_pend_q     <= 1'b0;
      v_data_q     <= '0;
      out_valid_q  <= 1'b0;
      out_fmt_q    <= 1'b0;
      out_data_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      drain_q    <= drain_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_din_q <= din;
        s1_fv_q  <= force_verbatim;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_verb_q <= s1_fv_q || !(no_edge || one_edge);
        s2_two_q  <= one_edge;
        s2_data_q <= s1_din_q;
        s2_v0_q   <= s1_din_q[IN_WIDTH-1];
        s2_c0_q   <= no_edge ? CB'(IN_WIDTH) : CB'(IN_WIDTH - 1) - k_idx;
        s2_v1_q   <= s1_din_q[0];
        s2_c1_q   <= k_idx + CB'(1);
      end
      r_num_q      <= r_num_d;
      r_val_q      <= r_val_d;
      r_cnt_q      <= r_cnt_d;
      v_pend_q     <= v_pend_d;
      v_data_q     <= v_data_d;
      out_valid_q  <= emit;
      out_fmt_q    <= emit_fmt;
      out_data_q   <= emit_data;
      flush_done_q <= (drain_q == 2'd3);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_format = out_fmt_q;
  assign out_data   = out_data_q;
  assign flush_done = flush_done_q;

`ifdef LOGIC_POD_RLE_STATS_EN
  logic [31:0] blocks_q, chunks_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blocks_q <= '0;
      chunks_q <= '0;
    end else begin
      if (accept && blocks_q != '1) blocks_q <= blocks_q + 32'd1;
      if (emit && chunks_q != '1)   chunks_q <= chunks_q + 32'd1;
    end
  end
  assign stat_blocks_in  = blocks_q;
  assign stat_chunks_out = chunks_q;
`else
  assign stat_blocks_in  = '0;
  assign stat_chunks_out = '0;
`endif

endmodule

// File: tb/tb_logic_pod_rle_compressor.sv
// tb/tb_logic_pod_rle_compressor.sv - directed bench for logic_pod_rle_compressor
module tb_logic_pod_rle_compressor;
  localparam int W = 16;
`ifdef LOGIC_POD_RLE_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, en, force_verbatim, flush;
  logic [W-1:0] din;
  logic         flush_done, out_valid, out_format;
  logic [W-1:0] out_data;
  logic [31:0]  stat_blocks_in, stat_chunks_out;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  logic_pod_rle_compressor #(.IN_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .din             (din),
    .in_valid        (in_valid),
    .en              (en),
    .force_verbatim  (force_verbatim),
    .flush           (flush),
    .flush_done      (flush_done),
    .out_valid       (out_valid),
    .out_format      (out_format),
    .out_data        (out_data),
    .stat_blocks_in  (stat_blocks_in),
    .stat_chunks_out (stat_chunks_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic efmt, input logic [W-1:0] edata);
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".data"}, 32'(out_data), 32'(edata));
    if (ev) check({tag, ".fmt"}, 32'(out_format), 32'(efmt));
  endtask

  task automatic block(input logic [W-1:0] d);
    din      = d;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    din      = '0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; force_verbatim = 1'b0; flush = 1'b0;
    idle();
    tick();
    tick();
    expect_out("reset", 1'b0, 1'b0, 16'h0000);
    check("reset.fmt", 32'(out_format), 32'd0);
    check("reset.done", 32'(flush_done), 32'd0);
    check("reset.blk", stat_blocks_in, 32'd0);
    check("reset.chk", stat_chunks_out, 32'd0);
    rst_n = 1'b1;

    // Eight zero blocks saturate at 127 and spill 1; drain emits them.
    for (int i = 0; i < 8; i++) begin
      block(16'h0000);
      tick();
      expect_out($sformatf("zeros%0d", i), 1'b0, 1'b0, 16'h0000);
    end
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("z.f1", 1'b0, 1'b0, 16'h0000);
    block(16'h5A5A);                      // dropped on F+1..F+3
    tick();
    expect_out("z.f2", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("z.f3", 1'b1, 1'b0, 16'h7F01);
    check("z.done_f3", 32'(flush_done), 32'd0);
    tick();
    idle();
    expect_out("z.f4", 1'b0, 1'b0, 16'h0000);
    check("z.done_f4", 32'(flush_done), 32'd1);
    tick();
    check("z.done_f5", 32'(flush_done), 32'd0);
    expect_out("z.f5", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("z.f6", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("z.f7", 1'b0, 1'b0, 16'h0000);

    // Direct verbatim at T+3.
    block(16'hA5A5);
    tick();
    expect_out("a5.t1", 1'b0, 1'b0, 16'h0000);
    idle();
    tick();
    expect_out("a5.t2", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("a5.t3", 1'b1, 1'b1, 16'hA5A5);
    tick();
    expect_out("a5.t4", 1'b0, 1'b0, 16'h0000);

    // Two-run block, merge, then verbatim pushes runs out; flush releases V.
    block(16'h00FF);
    tick();
    expect_out("mx.t1", 1'b0, 1'b0, 16'h0000);
    block(16'hFFFF);
    tick();
    expect_out("mx.t2", 1'b0, 1'b0, 16'h0000);
    block(16'h1234);
    tick();
    expect_out("mx.t3", 1'b0, 1'b0, 16'h0000);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("mx.t4", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("mx.t5", 1'b1, 1'b0, 16'h0898);
    tick();
    expect_out("mx.t6", 1'b1, 1'b1, 16'h1234);
    tick();
    expect_out("mx.t7", 1'b0, 1'b0, 16'h0000);
    check("mx.done", 32'(flush_done), 32'd1);

    // Third run forces a chunk; flush emits the leftover single run.
    block(16'hFFFF);
    tick();
    expect_out("alt.t1", 1'b0, 1'b0, 16'h0000);
    block(16'h0000);
    tick();
    expect_out("alt.t2", 1'b0, 1'b0, 16'h0000);
    block(16'hFFFF);
    tick();
    expect_out("alt.t3", 1'b0, 1'b0, 16'h0000);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("alt.t4", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("alt.t5", 1'b1, 1'b0, 16'h9010);
    tick();
    expect_out("alt.t6", 1'b1, 1'b0, 16'h9000);
    tick();
    check("alt.done", 32'(flush_done), 32'd1);

    // en low drops the block.
    en = 1'b0;
    block(16'h5555);
    tick();
    idle();
    en = 1'b1;
    tick();
    tick();
    expect_out("en.t3", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("en.t4", 1'b0, 1'b0, 16'h0000);

    // Forced verbatim, counters from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    force_verbatim = 1'b1;
    block(16'h0000);
    tick();
    expect_out("fv.t1", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("fv.t2", 1'b0, 1'b0, 16'h0000);
    tick();
    idle();
    force_verbatim = 1'b0;
    expect_out("fv.t3", 1'b1, 1'b1, 16'h0000);
    tick();
    expect_out("fv.t4", 1'b1, 1'b1, 16'h0000);
    tick();
    expect_out("fv.t5", 1'b1, 1'b1, 16'h0000);
    tick();
    expect_out("fv.t6", 1'b0, 1'b0, 16'h0000);
    check("fv.blocks", stat_blocks_in, 32'(3 * STATS_ON));
    check("fv.chunks", stat_chunks_out, 32'(3 * STATS_ON));

    // Runs pending, reset, then flush: nothing emitted.
    block(16'h0000);
    tick();
    idle();
    tick();
    tick();
    expect_out("rf.pend", 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_out("rf.rst", 1'b0, 1'b0, 16'h0000);
    check("rf.rst_blk", stat_blocks_in, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_out("rf.f1", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("rf.f2", 1'b0, 1'b0, 16'h0000);
    tick();
    expect_out("rf.f3", 1'b0, 1'b0, 16'h0000);
    check("rf.done_f3", 32'(flush_done), 32'd0);
    tick();
    expect_out("rf.f4", 1'b0, 1'b0, 16'h0000);
    check("rf.done_f4", 32'(flush_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/logic_pod_rle_compressor.md
# logic_pod_rle_compressor

Parametrised run-length compression engine for one logic-analyzer lane, the successor to the fixed 16-bit lane compressor. It accepts IN_WIDTH-bit sample blocks, qualified by a valid strobe, and classifies each block as one run, two runs or incompressible. It merges runs across blocks and emits at most one (1 + IN_WIDTH)-bit chunk per clock toward the capture FIFO. New over the previous generation: width generalisation, input qualifier, forced-verbatim mode, a pipeline-draining flush and optional statistics.

## Interface
- IN_WIDTH, default 16: block width in bits. Must be even and in the range 12..64.
- CB (localparam), value IN_WIDTH/2-1: run count width.
- MAXC (localparam), value 2^CB-1: maximum run count.
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- din  in  IN_WIDTH  sample block; MSB is the oldest sample.
- in_valid  in  1  din qualifier.
- en  in  1  capture enable; blocks are dropped while low.
- force_verbatim  in  1  treat every block as incompressible.
- flush  in  1  single-cycle drain request.
- flush_done  out  1  single-cycle drain-complete pulse.
- out_valid  out  1  chunk strobe.
- out_format  out  1  1 = verbatim, 0 = runs.
- out_data  out  IN_WIDTH  chunk payload.
- stat_blocks_in  out  32  accepted block count (see Configuration).
- stat_chunks_out  out  32  emitted chunk count (see Configuration).

## Operation
- Chunk formats:
  - Verbatim: payload = din.
  - Runs: payload = {valA, cntA[CB-1:0], valB, cntB[CB-1:0]}.
  - cntB = 0 with valB = 0 marks an empty second slot.
- Stage 1: register din; the block is accepted when in_valid && en && !draining. Compute edges = din[W-1:1] ^ din[W-2:0].
- Stage 2: classify the block.
  - Zero edges: one run {din[MSB], W}.
  - One edge at bit k: two runs {din[MSB], W-1-k} then {din[0], k+1}.
  - Otherwise, or when force_verbatim is high: verbatim.
- Stage 3 (merge) state: up to two pending runs (R1, R2), or one pending verbatim block V. V and runs are never pending together.
- Runs block, no V pending: append each new run in order.
  - Same value as the last pending run: extend it. If the sum exceeds MAXC, saturate the last run to MAXC and append the remainder as a new run.
  - Different value: append as a new run.
  - After appending, if more than two runs exist (at most four), emit the first two as a runs chunk and keep the rest.
  - Never more than one chunk per cycle.
- Verbatim block, no pending state: emit it directly.
- Verbatim block, runs pending: emit the runs chunk; store the block as V.
- V pending, any new block: emit V. A new runs block becomes R1/R2; a new verbatim block becomes V.
- V pending, no new block: V stays pending.
- Flush (edge F; accepted only when not already draining):
  - A block accepted on cycle F is kept.
  - Blocks on cycles F+1..F+3 are dropped.
  - F+1, F+2: the pipeline drains with normal merging.
  - F+3: emit V if pending, else runs if pending, then clear all state.
  - flush_done is high on F+4.
- rst_n low: clear pipeline valids, pending state, draining, out_valid, flush_done and the stats counters. This applies mid-flush or with blocks pending; nothing is emitted.

## Timing
- All outputs are registered.
- Reset values: out_valid = 0, out_format = 0, out_data = 0, flush_done = 0, stat_* = 0.
- Latency: a block accepted at cycle T affects out_* at T+3. A directly emitted verbatim block appears at T+3.
- out_data is zero whenever out_valid = 0.
- No backpressure: the consumer must accept one chunk per clock.
- en deasserted: pending state is held, not emitted.
- flush while draining is ignored. rst_n takes priority over flush.

## Configuration
- LOGIC_POD_RLE_STATS_EN defined:
  - stat_blocks_in counts blocks accepted at stage 1.
  - stat_chunks_out counts cycles with out_valid high.
  - Both counters saturate at 2^32-1.
- LOGIC_POD_RLE_STATS_EN undefined: both ports are tied to 0 and no counters are built.

## Test plan
All scenarios use IN_WIDTH = 16 (MAXC = 127).
- Eight blocks of 0x0000, then flush -> no output until the drain; at F+3, fmt 0, data 0x7F01; flush_done at F+4.
- Block 0xA5A5 at T, nothing pending -> fmt 1, data 0xA5A5 at T+3.
- 0x00FF, 0xFFFF, 0x1234 on consecutive cycles -> fmt 0, data 0x0898; next cycle fmt 1, data 0x1234.
- 0xFFFF, 0x0000, 0xFFFF -> fmt 0, data 0x9010 when the third block merges; flush then yields fmt 0, data 0x9000.
- force_verbatim = 1, three blocks of 0x0000 -> three fmt 1 chunks, data 0x0000, on consecutive cycles. With LOGIC_POD_RLE_STATS_EN: stat_blocks_in = 3, stat_chunks_out = 3.
- Runs pending, rst_n low one cycle, then flush -> out_valid never asserts; flush_done at F+4.
